// File: rtl/blanking_sync_generator_pkg.sv
// Shared video timing package.
// Holds the default 640x480@60 timing, the count width used by every
// column/row counter, and the sync/blank decode helpers. The blank decode
// is shared with the sync-to-blanking receiver so both sides agree on
// which positions are blanked.
package blanking_sync_generator_pkg;

  localparam int COUNT_W   = 10;
  localparam int MAX_COUNT = 1 << COUNT_W;

  localparam int DEF_TOTAL_COLS       = 800;
  localparam int DEF_TOTAL_ROWS       = 525;
  localparam int DEF_ACTIVE_COLS      = 640;
  localparam int DEF_ACTIVE_ROWS      = 480;
  localparam int DEF_SYNC_PULSE_HORZ  = 96;
  localparam int DEF_SYNC_PULSE_VERT  = 2;
  localparam int DEF_FRONT_PORCH_HORZ = 16;
  localparam int DEF_BACK_PORCH_HORZ  = 48;
  localparam int DEF_FRONT_PORCH_VERT = 10;
  localparam int DEF_BACK_PORCH_VERT  = 33;

  // Position 0 is the first cycle of the sync pulse, so blanking covers
  // sync + back porch at the start of the axis and the front porch at the end.
  function automatic logic axis_blank(input int pos, input int sync_w,
                                      input int back_w, input int front_w,
                                      input int total);
    return (pos < sync_w + back_w) || (pos > total - front_w - 1);
  endfunction

  // Active-low sync: low while the position is inside the sync pulse.
  function automatic logic axis_sync_n(input int pos, input int sync_w);
    return !(pos < sync_w);
  endfunction

endpackage

// File: rtl/blanking_sync_generator_if.sv
// Video timing bundle between the generator and its consumers.
// master: the side that drives the pixel strobe / restart and reads timing.
// slave : the generator itself.
//   i_Pix_En      pixel strobe, one position step per clock where high
//   i_Restart     abandon the frame and return to idle
//   o_nHSync      active-low horizontal sync
//   o_nVSync      active-low vertical sync
//   o_HBlank      horizontal blanking
//   o_VBlank      vertical blanking
//   o_Active      visible pixel flag
//   o_Col_Count   current column
//   o_Row_Count   current row
//   o_Line_Start  one-clock pulse when column 0 is first presented
//   o_Frame_Start one-clock pulse when (0,0) is first presented
interface blanking_sync_generator_if;
  import blanking_sync_generator_pkg::*;

  logic               i_Pix_En;
  logic               i_Restart;
  logic               o_nHSync;
  logic               o_nVSync;
  logic               o_HBlank;
  logic               o_VBlank;
  logic               o_Active;
  logic [COUNT_W-1:0] o_Col_Count;
  logic [COUNT_W-1:0] o_Row_Count;
  logic               o_Line_Start;
  logic               o_Frame_Start;

  modport master (
    output i_Pix_En, i_Restart,
    input  o_nHSync, o_nVSync, o_HBlank, o_VBlank, o_Active,
           o_Col_Count, o_Row_Count, o_Line_Start, o_Frame_Start
  );

  modport slave (
    input  i_Pix_En, i_Restart,
    output o_nHSync, o_nVSync, o_HBlank, o_VBlank, o_Active,
           o_Col_Count, o_Row_Count, o_Line_Start, o_Frame_Start
  );

endinterface

// File: rtl/sync_axis_counter.sv
// One axis of the timing generator: a wrap counter with registered
// sync and blank decode for the position it presents.
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       return to reset values (count 0, sync/blank inactive/blanked)
//   load        present position 0 with its decode (start of run)
//   step        advance one position, wrapping at TOTAL-1
//   count       presented position
//   at_last     presented position is TOTAL-1 (next step wraps)
//   sync_n      registered active-low sync for the presented position
//   blank       registered blank for the presented position
//   blank_next  blank value that will be presented after the next edge
module sync_axis_counter
  import blanking_sync_generator_pkg::*;
#(
  parameter int TOTAL   = DEF_TOTAL_COLS,
  parameter int SYNC_W  = DEF_SYNC_PULSE_HORZ,
  parameter int BACK_W  = DEF_BACK_PORCH_HORZ,
  parameter int FRONT_W = DEF_FRONT_PORCH_HORZ
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic               step,
  output logic [COUNT_W-1:0] count,
  output logic               at_last,
  output logic               sync_n,
  output logic               blank,
  output logic               blank_next
);

  logic [COUNT_W-1:0] count_q, count_d, pos_next;
  logic               sync_n_q, sync_n_d;
  logic               blank_q, blank_d;

  assign at_last = (int'(count_q) == TOTAL - 1);

  // The decode is taken from the position about to be presented, so the
  // registered flags always line up with the registered count.
  always_comb begin
    pos_next = at_last ? '0 : count_q + 1'b1;
    if (load) pos_next = '0;

    count_d  = count_q;
    sync_n_d = sync_n_q;
    blank_d  = blank_q;
    if (clear) begin
      count_d  = '0;
      sync_n_d = 1'b1;
      blank_d  = 1'b1;
    end else if (load || step) begin
      count_d  = pos_next;
      sync_n_d = axis_sync_n(int'(pos_next), SYNC_W);
      blank_d  = axis_blank(int'(pos_next), SYNC_W, BACK_W, FRONT_W, TOTAL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      sync_n_q <= 1'b1;
      blank_q  <= 1'b1;
    end else begin
      count_q  <= count_d;
      sync_n_q <= sync_n_d;
      blank_q  <= blank_d;
    end
  end

  assign count      = count_q;
  assign sync_n     = sync_n_q;
  assign blank      = blank_q;
  assign blank_next = blank_d;

endmodule

// File: rtl/blanking_sync_generator.sv
// Free-running video timing generator (transmit side of the
// sync-to-blanking receiver). Column 0 / row 0 are the first cycle of
// their sync pulse, matching the receiver's numbering.
//   i_Clk   system clock
//   i_nRst  asynchronous active-low reset
//   vid     timing bundle (slave): pixel strobe and restart in, sync,
//           blank, active, counts and line/frame start pulses out.
// All outputs are registered and describe the same presented position.
module blanking_sync_generator
  import blanking_sync_generator_pkg::*;
#(
  parameter int TOTAL_COLS       = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS       = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS      = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS      = DEF_ACTIVE_ROWS,
  parameter int SYNC_PULSE_HORZ  = DEF_SYNC_PULSE_HORZ,
  parameter int SYNC_PULSE_VERT  = DEF_SYNC_PULSE_VERT,
  parameter int FRONT_PORCH_HORZ = DEF_FRONT_PORCH_HORZ,
  parameter int BACK_PORCH_HORZ  = DEF_BACK_PORCH_HORZ,
  parameter int FRONT_PORCH_VERT = DEF_FRONT_PORCH_VERT,
  parameter int BACK_PORCH_VERT  = DEF_BACK_PORCH_VERT
) (
  input logic                      i_Clk,
  input logic                      i_nRst,
  blanking_sync_generator_if.slave vid
);

  if (TOTAL_COLS > MAX_COUNT || TOTAL_ROWS > MAX_COUNT) begin : g_bad_size
    $error("blanking_sync_generator: totals exceed the 10-bit counters");
  end
  if (SYNC_PULSE_HORZ + BACK_PORCH_HORZ + ACTIVE_COLS + FRONT_PORCH_HORZ
      != TOTAL_COLS) begin : g_bad_horz
    $error("blanking_sync_generator: horizontal timing does not sum to TOTAL_COLS");
  end
  if (SYNC_PULSE_VERT + BACK_PORCH_VERT + ACTIVE_ROWS + FRONT_PORCH_VERT
      != TOTAL_ROWS) begin : g_bad_vert
    $error("blanking_sync_generator: vertical timing does not sum to TOTAL_ROWS");
  end

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0] state_q, state_d;
  logic       start, advance, v_step;
  logic       h_last, v_last;
  logic       h_sync_n, v_sync_n, h_blank, v_blank;
  logic       h_blank_next, v_blank_next;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       active_q, active_d;
  logic [COUNT_W-1:0] col_count, row_count;

  // Restart outranks the strobe, so it masks both the start and the step.
  assign start   = (state_q == ST_IDLE) && vid.i_Pix_En && !vid.i_Restart;
  assign advance = (state_q == ST_RUN)  && vid.i_Pix_En && !vid.i_Restart;
  assign v_step  = advance && h_last;

  sync_axis_counter #(
    .TOTAL   (TOTAL_COLS),
    .SYNC_W  (SYNC_PULSE_HORZ),
    .BACK_W  (BACK_PORCH_HORZ),
    .FRONT_W (FRONT_PORCH_HORZ)
  ) u_horz (
    .clk        (i_Clk),
    .rst_n      (i_nRst),
    .clear      (vid.i_Restart),
    .load       (start),
    .step       (advance),
    .count      (col_count),
    .at_last    (h_last),
    .sync_n     (h_sync_n),
    .blank      (h_blank),
    .blank_next (h_blank_next)
  );

  // The row only moves on the column wrap, so vertical sync/blank can
  // only change when the column returns to 0.
  sync_axis_counter #(
    .TOTAL   (TOTAL_ROWS),
    .SYNC_W  (SYNC_PULSE_VERT),
    .BACK_W  (BACK_PORCH_VERT),
    .FRONT_W (FRONT_PORCH_VERT)
  ) u_vert (
    .clk        (i_Clk),
    .rst_n      (i_nRst),
    .clear      (vid.i_Restart),
    .load       (start),
    .step       (v_step),
    .count      (row_count),
    .at_last    (v_last),
    .sync_n     (v_sync_n),
    .blank      (v_blank),
    .blank_next (v_blank_next)
  );

  // Pulses are computed from the same step that moves the counters, so
  // they land on the edge that first presents column 0 / (0,0).
  always_comb begin
    state_d = state_q;
    if (vid.i_Restart) state_d = ST_IDLE;
    else if (start)    state_d = ST_RUN;

    line_start_d  = start || v_step;
    frame_start_d = start || (v_step && v_last);
    active_d      = !h_blank_next && !v_blank_next;
  end

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state_q       <= ST_IDLE;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      active_q      <= active_d;
    end
  end

  assign vid.o_nHSync      = h_sync_n;
  assign vid.o_nVSync      = v_sync_n;
  assign vid.o_HBlank      = h_blank;
  assign vid.o_VBlank      = v_blank;
  assign vid.o_Active      = active_q;
  assign vid.o_Col_Count   = col_count;
  assign vid.o_Row_Count   = row_count;
  assign vid.o_Line_Start  = line_start_q;
  assign vid.o_Frame_Start = frame_start_q;

endmodule
